// File: rtl/hub75_bcm_scheduler_if.sv
// Transmitter command handshake between the BCM scheduler (master) and the HUB75 shift transmitter (slave).
interface hub75_bcm_scheduler_if #(
  parameter int hpixel_p = 64,
  parameter int vpixel_p = 64,
  parameter int bpp_p    = 8
);
  logic                                   o_tx_start;
  logic [$clog2(hpixel_p*vpixel_p)-1:0]   o_init_addr;
  logic [$clog2(bpp_p)-1:0]               o_pix_bit;
  logic                                   i_tx_ready;

  modport master (output o_tx_start, output o_init_addr, output o_pix_bit, input i_tx_ready);
  modport slave  (input o_tx_start, input o_init_addr, input o_pix_bit, output i_tx_ready);
endinterface

// File: rtl/hub75_bcm_scheduler.sv
// Frame sequencer: per row and bit plane, commands a shift, waits for latch, then blanks and drives OE for base<<plane cycles.
// Optional HUB75_BRIGHTNESS_EN adds i_brightness, which scales the OE-low portion of each display window.
module hub75_bcm_scheduler #(
  parameter int hpixel_p   = 64,
  parameter int vpixel_p   = 64,
  parameter int bpp_p      = 8,
  parameter int segments_p = 2,
  parameter int time_wd_p  = 16,
  localparam int rows_p    = vpixel_p / segments_p,
  localparam int row_w_p   = $clog2(rows_p)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enable,
  input  logic [time_wd_p-1:0]   i_base_time,
  input  logic [7:0]             i_blank_time,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]             i_brightness,
`endif
  hub75_bcm_scheduler_if.master  tx,
  output logic [row_w_p-1:0]     o_row_addr,
  output logic                   o_oe_n,
  output logic                   o_busy,
  output logic                   o_frame_done
);

  localparam int addr_w_p = $clog2(hpixel_p * vpixel_p);
  localparam int pix_w_p  = $clog2(bpp_p);
  localparam int cnt_w_p  = time_wd_p + bpp_p;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] BLANK     = 3'd4;
  localparam logic [2:0] DISPLAY   = 3'd5;
  localparam logic [2:0] NEXT      = 3'd6;

  logic [2:0]           state;
  logic [row_w_p-1:0]   row;
  logic [pix_w_p-1:0]   plane;
  logic [cnt_w_p-1:0]   cnt;
  logic [time_wd_p-1:0] base_q;
  logic [7:0]           blank_q;
  logic [time_wd_p-1:0] base_eff;
  logic [7:0]           blank_eff;
  logic [cnt_w_p-1:0]   window;
  logic                 plane_last;
  logic                 row_last;

  assign base_eff   = (base_q == '0) ? time_wd_p'(1) : base_q;
  assign blank_eff  = (blank_q == '0) ? 8'd1 : blank_q;
  // Counter is wide enough for the largest base shifted by the top plane.
  assign window     = cnt_w_p'(base_eff) << plane;
  assign plane_last = (plane == pix_w_p'(bpp_p - 1));
  assign row_last   = (row == row_w_p'(rows_p - 1));

  assign tx.o_tx_start  = (state == START) && tx.i_tx_ready;
  assign tx.o_init_addr = addr_w_p'(row) * addr_w_p'(hpixel_p);
  assign tx.o_pix_bit   = plane;
  assign o_busy         = (state != IDLE);
  assign o_frame_done   = (state == NEXT) && plane_last && row_last;

`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]           bright_q;
  logic [8:0]           bright_p1;
  logic [cnt_w_p+8:0]   prod;
  logic [cnt_w_p:0]     on_len;

  assign bright_p1 = {1'b0, bright_q} + 9'd1;
  assign prod      = (cnt_w_p+9)'(window) * (cnt_w_p+9)'(bright_p1);
  assign on_len    = (cnt_w_p+1)'(prod >> 8);
  assign o_oe_n    = !((state == DISPLAY) && ({1'b0, cnt} < on_len));
`else
  assign o_oe_n    = (state != DISPLAY);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      row        <= '0;
      plane      <= '0;
      cnt        <= '0;
      base_q     <= '0;
      blank_q    <= '0;
      o_row_addr <= '0;
`ifdef HUB75_BRIGHTNESS_EN
      bright_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            base_q  <= i_base_time;
            blank_q <= i_blank_time;
`ifdef HUB75_BRIGHTNESS_EN
            bright_q <= i_brightness;
`endif
            row     <= '0;
            plane   <= '0;
            state   <= START;
          end
        end
        START: begin
          if (tx.i_tx_ready) state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (!tx.i_tx_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx.i_tx_ready) begin
            o_row_addr <= row;
            cnt        <= '0;
            state      <= BLANK;
          end
        end
        BLANK: begin
          if (cnt == cnt_w_p'(blank_eff - 8'd1)) begin
            cnt   <= '0;
            state <= DISPLAY;
          end else begin
            cnt <= cnt + cnt_w_p'(1);
          end
        end
        DISPLAY: begin
          if (cnt == window - cnt_w_p'(1)) begin
            cnt   <= '0;
            state <= NEXT;
          end else begin
            cnt <= cnt + cnt_w_p'(1);
          end
        end
        NEXT: begin
          if (!plane_last) begin
            plane <= plane + pix_w_p'(1);
            state <= START;
          end else begin
            plane <= '0;
            if (!row_last) begin
              row   <= row + row_w_p'(1);
              state <= START;
            end else begin
              // Frame boundary: the only place enable and config are looked at again.
              row <= '0;
              if (i_enable) begin
                base_q  <= i_base_time;
                blank_q <= i_blank_time;
`ifdef HUB75_BRIGHTNESS_EN
                bright_q <= i_brightness;
`endif
                state   <= START;
              end else begin
                state <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scheduler.sv
// Directed bench for hub75_bcm_scheduler on a 4x4, 2-segment, 2-plane panel with a 10-cycle transmitter model.
module tb_hub75_bcm_scheduler;
  localparam int HP = 4, VP = 4, BPP = 2, SEG = 2, TW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [TW-1:0] base_time = 16'd3;
  logic [7:0]    blank_time = 8'd2;
  logic [0:0]    row_addr;
  logic          oe_n, busy, frame_done;
`ifdef HUB75_BRIGHTNESS_EN
  logic [7:0]    brightness = 8'd0;
`endif

  hub75_bcm_scheduler_if #(.hpixel_p(HP), .vpixel_p(VP), .bpp_p(BPP)) tx_if ();

  hub75_bcm_scheduler #(
    .hpixel_p(HP), .vpixel_p(VP), .bpp_p(BPP), .segments_p(SEG), .time_wd_p(TW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (enable),
    .i_base_time  (base_time),
    .i_blank_time (blank_time),
`ifdef HUB75_BRIGHTNESS_EN
    .i_brightness (brightness),
`endif
    .tx           (tx_if.master),
    .o_row_addr   (row_addr),
    .o_oe_n       (oe_n),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor and transmitter model state
  int   start_addr[$], start_bit[$], windows[$], gaps[$], gap_rows[$];
  int   run = 0, gap = 0, gap_act = 0, row_viol = 0;
  int   fd_cnt = 0, fd_win = 0, idle_cnt = 0;
  int   busy_left = 0, dly = 0;
  logic watch_idle = 1'b0;
  logic ready_prev = 1'b1;
  logic row_prev = 1'b0;
  logic st;

  always @(negedge clk) begin
    if (!rst_n) begin
      tx_if.i_tx_ready = 1'b1;
      busy_left = 0; dly = 0; run = 0; gap_act = 0; ready_prev = 1'b1;
    end else begin
      if (tx_if.o_tx_start) begin
        start_addr.push_back(int'(tx_if.o_init_addr));
        start_bit.push_back(int'(tx_if.o_pix_bit));
      end
      if (!oe_n && row_addr !== row_prev) row_viol++;
      row_prev = row_addr;
      if (!oe_n) run++;
      else if (run > 0) begin windows.push_back(run); run = 0; end
      if (tx_if.i_tx_ready && !ready_prev) begin
        gap_act = 1; gap = 0; gap_rows.push_back(int'(row_addr));
      end
      if (gap_act != 0) begin
        if (oe_n) gap++;
        else begin gaps.push_back(gap); gap_act = 0; end
      end
      if (frame_done) begin fd_cnt++; fd_win = windows.size(); end
      if (watch_idle && !busy) idle_cnt++;
      ready_prev = tx_if.i_tx_ready;
      // Transmitter: ready drops one cycle after start and stays low 10 cycles.
      st = tx_if.o_tx_start;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_if.i_tx_ready = 1'b1;
      end else if (dly != 0) begin
        tx_if.i_tx_ready = 1'b0; busy_left = 10; dly = 0;
      end
      if (st) dly = 1;
    end
  end

  task automatic clear_logs();
    start_addr.delete(); start_bit.delete(); windows.delete(); gaps.delete(); gap_rows.delete();
    fd_cnt = 0; fd_win = 0; row_viol = 0; idle_cnt = 0;
  endtask

  initial begin
    int exp_addr[4] = '{0, 0, 4, 4};
    int exp_bit[4]  = '{0, 1, 0, 1};
    int exp_win[4]  = '{3, 6, 3, 6};
    int exp_row[4]  = '{0, 0, 1, 1};

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_oe_n", oe_n, 1);
    check_eq("rst_tx_start", tx_if.o_tx_start, 0);
    check_eq("rst_row_addr", row_addr, 0);
    check_eq("rst_init_addr", tx_if.o_init_addr, 0);
    check_eq("rst_pix_bit", tx_if.o_pix_bit, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);

    // Frame 1: base=3, blank=2
    rst_n = 1'b1;
    enable = 1'b1;
    @(posedge clk); #1;
    watch_idle = 1'b1;
    for (int i = 0; i < 3000 && fd_cnt < 1; i++) @(posedge clk);
    check_eq("f1_frame_done", fd_cnt, 1);
    check_eq("f1_done_after_win", fd_win, 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("f1_addr%0d", i), (start_addr.size() > i) ? start_addr[i] : -1, exp_addr[i]);
      check_eq($sformatf("f1_bit%0d", i), (start_bit.size() > i) ? start_bit[i] : -1, exp_bit[i]);
      check_eq($sformatf("f1_win%0d", i), (windows.size() > i) ? windows[i] : -1, exp_win[i]);
      check_eq($sformatf("f1_blank%0d", i), (gaps.size() > i) ? gaps[i] : -1, 2);
      check_eq($sformatf("f1_row%0d", i), (gap_rows.size() > i) ? gap_rows[i] : -1, exp_row[i]);
    end

    // Frame 2 follows without an IDLE cycle; drop enable during its row 0
    for (int i = 0; i < 200 && start_addr.size() < 5; i++) @(posedge clk);
    check_eq("f2_started", start_addr.size(), 5);
    check_eq("f2_addr0", (start_addr.size() > 4) ? start_addr[4] : -1, 0);
    check_eq("f2_bit0", (start_bit.size() > 4) ? start_bit[4] : -1, 0);
    check_eq("no_idle_between", idle_cnt, 0);
    #1;
    enable = 1'b0;
    watch_idle = 1'b0;
    for (int i = 0; i < 3000 && fd_cnt < 2; i++) @(posedge clk);
    check_eq("f2_frame_done", fd_cnt, 2);
    repeat (30) @(posedge clk);
    #1;
    check_eq("stop_starts", start_addr.size(), 8);
    check_eq("stop_windows", windows.size(), 8);
    check_eq("stop_frame_done", fd_cnt, 2);
    check_eq("stop_busy", busy, 0);
    check_eq("stop_oe_n", oe_n, 1);
    check_eq("row_only_when_oe_high", row_viol, 0);

    // base=0, blank=0 behave as 1
    rst_n = 1'b0;
    base_time = 16'd0;
    blank_time = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3000 && fd_cnt < 1; i++) @(posedge clk);
    check_eq("z_frame_done", fd_cnt, 1);
    check_eq("z_win0", (windows.size() > 0) ? windows[0] : -1, 1);
    check_eq("z_win1", (windows.size() > 1) ? windows[1] : -1, 2);
    check_eq("z_blank0", (gaps.size() > 0) ? gaps[0] : -1, 1);
    check_eq("z_blank1", (gaps.size() > 1) ? gaps[1] : -1, 1);

    // Reset during a row-1 display window
    begin
      int seen = 0;
      for (int i = 0; i < 500 && seen == 0; i++) begin
        @(posedge clk); #1;
        if (!oe_n && row_addr == 1'b1) seen = 1;
      end
      check_eq("mid_disp_reached", seen, 1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_eq("abort_oe_n", oe_n, 1);
    check_eq("abort_tx_start", tx_if.o_tx_start, 0);
    check_eq("abort_row_addr", row_addr, 0);
    check_eq("abort_busy", busy, 0);
    enable = 1'b0;

`ifdef HUB75_BRIGHTNESS_EN
    base_time = 16'd4;
    blank_time = 8'd2;
    brightness = 8'd127;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3000 && fd_cnt < 1; i++) @(posedge clk);
    check_eq("br_frame_done", fd_cnt, 1);
    check_eq("br_win0", (windows.size() > 0) ? windows[0] : -1, 2);
    check_eq("br_win1", (windows.size() > 1) ? windows[1] : -1, 4);
    rst_n = 1'b0;
    enable = 1'b0;
    base_time = 16'd1;
    brightness = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    clear_logs();
    rst_n = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 3000 && fd_cnt < 1; i++) @(posedge clk);
    check_eq("br0_frame_done", fd_cnt, 1);
    check_eq("br0_oe_never_low", windows.size(), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hub75_bcm_scheduler.md
Name: hub75_bcm_scheduler

Overview:
- Frame-level sequencer for the HUB75 colour shift transmitter.
- Walks every display row and every bit plane in binary-coded-modulation (BCM) order. For each plane it commands one row shift (start, start address, bit index), waits for the shift and latch to finish, then sets the row address lines and drives output-enable for a time weighted by the bit position.
- Sits between the frame buffer / transmitter and the panel's row address and OE pins.

Parameters:
- hpixel_p, 64: display width in pixels.
- vpixel_p, 64: display height in pixels.
- bpp_p, 8: bits per colour channel, which is also the number of bit planes.
- segments_p, 2: display segments driven in parallel; rows_p = vpixel_p/segments_p.
- time_wd_p, 16: width of the base display-time input.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous, active-low reset.
- i_enable  in  1  run frames continuously while high.
- i_base_time  in  time_wd_p  OE-low cycles for bit plane 0; a value of 0 is treated as 1.
- i_blank_time  in  8  OE-high cycles before each display window, during which the row address settles.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- o_init_addr  out  $clog2(hpixel_p*vpixel_p)  start address of the row = row*hpixel_p.
- o_pix_bit  out  $clog2(bpp_p)  bit plane index for the transmitter.
- i_tx_ready  in  1  transmitter idle; low while a shift or latch is in progress.
- o_row_addr  out  $clog2(rows_p)  panel row select (A..E).
- o_oe_n  out  1  panel output enable, active low.
- o_busy  out  1  high in every state except IDLE.
- o_frame_done  out  1  one-cycle pulse at the end of each frame.

Behaviour:
- Reset values: o_tx_start=0, o_oe_n=1, o_row_addr=0, o_init_addr=0, o_pix_bit=0, o_busy=0, o_frame_done=0. The state machine goes to IDLE and all counters clear.
- Reset mid-operation aborts immediately. o_oe_n is high from the cycle after reset is sampled.
- States:
  - IDLE: when i_enable=1, sample i_base_time and i_blank_time, clear the row and plane counters, and go to START.
  - START: wait for i_tx_ready=1. In that cycle assert o_tx_start, with o_init_addr and o_pix_bit valid in the same cycle and held stable until the next START. Then go to WAIT_ACK.
  - WAIT_ACK: wait for i_tx_ready=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for i_tx_ready=1. This is latch completion. Then go to BLANK.
  - BLANK: o_oe_n=1. In the first BLANK cycle o_row_addr takes the current row. Stay i_blank_time cycles; a value of 0 means 1 cycle. Then go to DISPLAY.
  - DISPLAY: o_oe_n=0 for exactly max(base,1) << plane cycles. Use a counter of width time_wd_p+bpp_p with no overflow. Then go to NEXT.
  - NEXT: o_oe_n=1 and advance the counters:
    - plane+1 while plane < bpp_p-1, otherwise plane=0 and row+1;
    - after row rows_p-1 with plane bpp_p-1: pulse o_frame_done, then go to START if i_enable=1 (re-sampling the config), otherwise go to IDLE.
- o_row_addr changes only while o_oe_n=1. OE is never low in any state other than DISPLAY.
- Deasserting i_enable mid-frame has no effect until the frame boundary; the frame always completes.
- Config inputs are ignored except when sampled at frame start.
- Per-plane cycle count = start wait + transmitter time + max(blank,1) + (max(base,1) << plane) + 1.

Optional Feature:
- Macro: HUB75_BRIGHTNESS_EN.
- When defined:
  - adds port i_brightness, in, 8, sampled at frame start;
  - in DISPLAY the window length is unchanged, but o_oe_n is low only for the first (window*(i_brightness+1))>>8 cycles and high for the rest;
  - if that value is 0, OE stays high for the whole window.
- When undefined: no port, and OE is low for the full window.

Test Plan:
- hpixel_p=4, vpixel_p=4, segments_p=2, bpp_p=2, base=3, blank=2, transmitter model ready-drop 1 cycle after start for 10 cycles -> start sequence (addr,bit) = (0,0),(0,1),(4,0),(4,1); OE-low runs 3,6,3,6 cycles; o_frame_done pulses once after the 4th window.
- Same configuration, monitor o_row_addr vs o_oe_n -> row changes only with o_oe_n=1; row 0 then row 1; blank = 2 cycles before every window.
- base=0, blank=0 -> windows 1,2 cycles; blank 1 cycle.
- Drop i_enable during row 0 -> frame completes with 4 planes, one o_frame_done, then IDLE with o_busy=0 and o_oe_n=1. Keep i_enable high -> next frame starts at addr 0, bit 0 with no IDLE cycle.
- Assert rst_n=0 mid-DISPLAY -> next cycle o_oe_n=1, o_tx_start=0, o_row_addr=0, state IDLE.
- With HUB75_BRIGHTNESS_EN, i_brightness=127, base=4 -> plane 0 window 4 gives OE low 2 cycles; plane 1 window 8 gives OE low 4 cycles; i_brightness=0 with base=1 -> OE never low.
